// File: rtl/serial_sub.sv
// ---------------------------------------------------------------------------
// serial_sub
// Bit-serial N-bit subtractor. Computes a - b - borrowIn one bit per clock,
// LSB first, with a single full-subtractor cell and a registered borrow.
//
// Handshake (valid/ready in one place):
//   start is the request, accepted on any rising edge where the block is in
//   IDLE or DONE. a, b and borrowIn are captured on that same edge. busy is
//   high for exactly WIDTH cycles after the accept. done pulses for one cycle
//   afterwards, when diff/borrowOut carry the new result. A start held high in
//   the DONE cycle is accepted immediately, so consecutive operations have no
//   dead cycles. start is ignored while busy.
//
// Parameters:
//   WIDTH        operand/result width, 1..32
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        operation request
//   a            minuend (sampled on accept)
//   b            subtrahend (sampled on accept)
//   borrowIn     initial borrow (sampled on accept)
//   busy         high while bits are being computed
//   done         one-cycle pulse, result valid and newly updated
//   diff         registered result (a - b - borrowIn) mod 2^WIDTH
//   borrowOut    final borrow, 1 iff a < b + borrowIn (unsigned)
//   dbg_state_o  current FSM state (0 IDLE, 1 RUN, 2 DONE)
// ---------------------------------------------------------------------------
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrowIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrowOut,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // One extra counter bit beyond clog2 keeps WIDTH=1 (clog2=0) legal.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic             br_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;

    // Full-subtractor cell on the current LSBs.
    logic             bit_d;
    logic             br_d;
    logic [WIDTH-1:0] res_d;
    logic             accept;

    assign bit_d  = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
    assign br_d   = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Result bits enter at the MSB and move down, so after WIDTH shifts the
    // first (LSB) result bit has reached position 0.
    generate
        if (WIDTH == 1) begin : g_res_one
            assign res_d = bit_d;
        end else begin : g_res_many
            assign res_d = {bit_d, res_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        br_q    <= borrowIn;
                        cnt_q   <= '0;
                        res_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                S_RUN: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    br_q   <= br_d;
                    res_q  <= res_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        // Final bit: publish result, leaving the shift
                        // registers as they are until the next accept.
                        diff_q  <= res_d;
                        bout_q  <= br_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign diff        = diff_q;
    assign borrowOut   = bout_q;
    assign dbg_state_o = state_q;

    // busy and done are mutually exclusive, and busy tracks the RUN state.
    a_busy_done_excl: assert property (@(posedge clk) disable iff (rst)
        !(busy_q && done_q));
    a_busy_is_run: assert property (@(posedge clk) disable iff (rst)
        busy_q == (state_q == S_RUN));

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;

    logic clk;
    logic rst;

    // WIDTH=8 instance
    logic       st8, bin8, busy8, done8, bo8;
    logic [7:0] a8, b8, diff8;
    logic [1:0] dbg8;
    // WIDTH=4 instance
    logic       st4, bin4, busy4, done4, bo4;
    logic [3:0] a4, b4, diff4;
    logic [1:0] dbg4;
    // WIDTH=1 instance
    logic       st1, bin1, busy1, done1, bo1;
    logic [0:0] a1, b1, diff1;
    logic [1:0] dbg1;

    int n_tests;
    int n_fail;

    // Expected {borrowOut, diff} for the 4-bit sweep.
    logic [4:0] exp_q[$];

    serial_sub #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .borrowIn(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .borrowOut(bo8),
        .dbg_state_o(dbg8)
    );

    serial_sub #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(st4), .a(a4), .b(b4), .borrowIn(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .borrowOut(bo4),
        .dbg_state_o(dbg4)
    );

    serial_sub #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .borrowIn(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .borrowOut(bo1),
        .dbg_state_o(dbg1)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Launch one operation on the selected instance and wait for done.
    task automatic run_op(input int sel, input int av, input int bv,
                          input logic bi, output int dv, output logic bov,
                          output int busy_cycles);
        bit seen;
        a8 = av[7:0]; b8 = bv[7:0]; bin8 = bi;
        a4 = av[3:0]; b4 = bv[3:0]; bin4 = bi;
        a1 = av[0:0]; b1 = bv[0:0]; bin1 = bi;
        st8 = (sel == 8); st4 = (sel == 4); st1 = (sel == 1);
        tick();
        st8 = 1'b0; st4 = 1'b0; st1 = 1'b0;
        busy_cycles = 0;
        seen = 1'b0;
        dv = 0;
        bov = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (sel == 8 && done8) begin seen = 1'b1; dv = int'(diff8); bov = bo8; end
            if (sel == 4 && done4) begin seen = 1'b1; dv = int'(diff4); bov = bo4; end
            if (sel == 1 && done1) begin seen = 1'b1; dv = int'(diff1); bov = bo1; end
            if (seen) break;
            if ((sel == 8 && busy8) || (sel == 4 && busy4) || (sel == 1 && busy1))
                busy_cycles++;
            tick();
        end
        check("done_timeout", 32'(seen), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    int   dv, cyc, ndone, seen_diff, seen_bo;
    logic bov;
    // Full-subtractor truth table indexed by {a,b,bin}: {d, bout}.
    logic [1:0] fs_tab [8];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        fs_tab[0] = 2'b00; fs_tab[1] = 2'b11; fs_tab[2] = 2'b11; fs_tab[3] = 2'b01;
        fs_tab[4] = 2'b10; fs_tab[5] = 2'b00; fs_tab[6] = 2'b00; fs_tab[7] = 2'b11;

        st8 = 0; st4 = 0; st1 = 0;
        a8 = 0; b8 = 0; bin8 = 0; a4 = 0; b4 = 0; bin4 = 0; a1 = 0; b1 = 0; bin1 = 0;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_diff", 32'(diff8), 32'd0);
        check("rst_bo",   32'(bo8),   32'd0);
        check("rst_state", 32'(dbg8), 32'd0);
        rst = 1'b0;
        tick();

        // 5 - 3: cycle-exact busy/done timing
        a8 = 8'd5; b8 = 8'd3; bin8 = 1'b0; st8 = 1'b1;
        tick();
        st8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("t1_busy", 32'(busy8), 32'd1);
            check("t1_nodone", 32'(done8), 32'd0);
            tick();
        end
        check("t1_done", 32'(done8), 32'd1);
        check("t1_busy_low", 32'(busy8), 32'd0);
        check("t1_diff", 32'(diff8), 32'd2);
        check("t1_bo", 32'(bo8), 32'd0);
        check("t1_state_done", 32'(dbg8), 32'd2);
        tick();
        check("t1_done_pulse", 32'(done8), 32'd0);
        check("t1_diff_hold", 32'(diff8), 32'd2);

        // 3 - 5 and 0 - 0 - 1 (underflow)
        run_op(8, 3, 5, 1'b0, dv, bov, cyc);
        check("t2_diff", 32'(dv), 32'd254);
        check("t2_bo", 32'(bov), 32'd1);
        check("t2_busy_cycles", 32'(cyc), 32'd8);
        run_op(8, 0, 0, 1'b1, dv, bov, cyc);
        check("t2b_diff", 32'(dv), 32'd255);
        check("t2b_bo", 32'(bov), 32'd1);

        // Back-to-back with start held high
        tick();
        a8 = 8'd200; b8 = 8'd100; bin8 = 1'b0; st8 = 1'b1;
        tick();
        repeat (8) tick();
        check("b2b_done1", 32'(done8), 32'd1);
        check("b2b_diff1", 32'(diff8), 32'd100);
        check("b2b_bo1", 32'(bo8), 32'd0);
        a8 = 8'd100; b8 = 8'd200;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cyc++;
            if (done8) break;
            check("b2b_diff_hold", 32'(diff8), 32'd100);
            check("b2b_busy", 32'(busy8), 32'd1);
        end
        check("b2b_period", 32'(cyc), 32'd9);
        check("b2b_diff2", 32'(diff8), 32'd156);
        check("b2b_bo2", 32'(bo8), 32'd1);
        st8 = 1'b0;
        tick();
        check("b2b_idle", 32'(busy8), 32'd0);

        // start and operands toggled during RUN are ignored
        a8 = 8'd10; b8 = 8'd4; bin8 = 1'b0; st8 = 1'b1;
        tick();
        a8 = 8'd1; b8 = 8'd2; st8 = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            a8 = 8'(i * 37 + 3); b8 = 8'(i * 11 + 90); bin8 = i[0]; st8 = i[0];
            tick();
        end
        st8 = 1'b0; bin8 = 1'b0;
        ndone = 0; seen_diff = 0; seen_bo = 0;
        for (int i = 0; i < 15; i++) begin
            if (done8) begin
                ndone++;
                seen_diff = int'(diff8);
                seen_bo = int'(bo8);
            end
            tick();
        end
        check("ign_ndone", 32'(ndone), 32'd1);
        check("ign_diff", 32'(seen_diff), 32'd6);
        check("ign_bo", 32'(seen_bo), 32'd0);

        // Asynchronous reset in the middle of RUN
        a8 = 8'd9; b8 = 8'd1; st8 = 1'b1;
        tick();
        st8 = 1'b0;
        repeat (3) tick();
        check("ar_pre_busy", 32'(busy8), 32'd1);
        check("ar_pre_diff", 32'(diff8), 32'd6);
        #3;
        rst = 1'b1;
        #1;
        check("ar_busy", 32'(busy8), 32'd0);
        check("ar_done", 32'(done8), 32'd0);
        check("ar_diff", 32'(diff8), 32'd0);
        check("ar_bo", 32'(bo8), 32'd0);
        check("ar_state", 32'(dbg8), 32'd0);
        #1;
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) ndone++;
        end
        check("ar_no_done", 32'(ndone), 32'd0);
        run_op(8, 9, 9, 1'b0, dv, bov, cyc);
        check("ar_after_diff", 32'(dv), 32'd0);
        check("ar_after_bo", 32'(bov), 32'd0);

        // WIDTH=4 exhaustive sweep
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    int ed;
                    int eb;
                    logic [4:0] e;
                    ed = (ai - bi - ci) & 15;
                    eb = (ai < bi + ci) ? 1 : 0;
                    exp_q.push_back({eb[0], ed[3:0]});
                    run_op(4, ai, bi, ci[0], dv, bov, cyc);
                    e = exp_q.pop_front();
                    check("w4_diff", 32'(dv), 32'(e[3:0]));
                    check("w4_bo", 32'(bov), 32'(e[4]));
                    check("w4_cycles", 32'(cyc), 32'd4);
                end
            end
        end

        // WIDTH=1 against the full-subtractor truth table
        for (int k = 0; k < 8; k++) begin
            logic [1:0] t;
            t = fs_tab[k];
            run_op(1, (k >> 2) & 1, (k >> 1) & 1, k[0], dv, bov, cyc);
            check("w1_diff", 32'(dv), 32'(t[1]));
            check("w1_bo", 32'(bov), 32'(t[0]));
            check("w1_cycles", 32'(cyc), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
